ocm_wr_arbiter: RTL and testbench
=================================

// Module: ocm_wr_arbiter
// PURPOSE
//  Shares one AXI3 write port (AW/W/B) between two burst requesters (e.g. two stream-to-AXI controllers).
//  Round-robin grant per burst; grant is held from AW issue through the last W beat.
//  The block counts beats, generates AXI_wlast, tracks outstanding B responses and flags errors.
//  Sits between the requesters' controllers and the PS HP/OCM port, all in the AXI_clk domain.
// PARAMETERS
//  BURST_LEN   16  beats per burst (matches awlen=4'hf); 2..16
//  MAX_OUTST   4   maximum AW bursts awaiting B response; 1..15
// PORTS
//  AXI_clk       in   1   sole clock
//  rst           in   1   synchronous, active-high reset
//  m0_req        in   1   requester 0 has a full burst ready; hold until m0_grant
//  m0_awaddr     in   32  burst start address, sampled at grant
//  m0_grant      out  1   requester 0 owns the port (AW issue to last W beat)
//  m0_wdata      in   32  write beat data
//  m0_wvalid     in   1   beat valid
//  m0_wready     out  1   beat accepted = AXI_wready & m0_grant & in DATA
//  m1_*          --   --  identical set for requester 1
//  AXI_awaddr    out  32  registered burst address
//  AXI_awvalid   out  1   registered address valid
//  AXI_awready   in   1
//  AXI_wdata     out  32  muxed from granted requester
//  AXI_wvalid    out  1   granted requester's wvalid, gated by DATA state
//  AXI_wlast     out  1   high on beat BURST_LEN-1
//  AXI_wready    in   1
//  AXI_bvalid    in   1   bready is tied 1 outside this block
//  AXI_bresp     in   2
//  outst         out  4   outstanding B count
//  err           out  1   sticky: bresp!=OKAY or B with outst==0
//  burst_cnt     out  32  completed bursts (last W beat accepted), wraps
// BEHAVIOUR
//  Reset: state=IDLE, grants=0, AXI_awvalid=0, AXI_awaddr=0, AXI_wvalid=0, AXI_wlast=0,
//   outst=0, err=0, burst_cnt=0, beat=0, last=1 (so m0 wins the first tie).
//  Reset mid-burst aborts immediately (awvalid/wvalid drop); rst must be asserted with interconnect reset.
//  FSM IDLE->ADDR->DATA->IDLE:
//   IDLE: if outst<MAX_OUTST and any req: pick sole requester, or on tie the one !=last;
//    next cycle: mN_grant=1, AXI_awaddr=mN_awaddr, AXI_awvalid=1, state=ADDR (1-cycle req->awvalid latency).
//    If outst==MAX_OUTST: stay IDLE, no grant, requests wait.
//   ADDR: hold awaddr/awvalid until AXI_awready; on handshake awvalid=0, outst+1, state=DATA.
//    W beats are not forwarded in ADDR (no W before AW).
//   DATA: AXI_wdata/wvalid = granted mN; beat increments on AXI_wvalid&AXI_wready;
//    AXI_wlast = (beat==BURST_LEN-1), combinational from beat; on that handshake: beat=0, grant drops,
//    last=granted index, burst_cnt+1, state=IDLE. Earliest re-grant: 1 cycle later (IDLE cycle).
//  Ungranted requester always sees mN_wready=0 and mN_grant=0.
//  outst: +1 on AW handshake, -1 on AXI_bvalid; both same cycle -> unchanged.
//   bvalid at outst==0: outst stays 0, err set. Never exceeds MAX_OUTST.
//  err: set on AXI_bvalid with bresp!=2'b00; cleared only by rst.
//  burst_cnt wraps 0xFFFFFFFF->0. beat width 4 bits; never exceeds BURST_LEN-1.
//  Requester dropping mN_req after grant has no effect; burst completes.
// TESTING
//  m0_req, addr 0xFFFC0000, awready 1, wready 1 -> awvalid 1 cycle after req, 16 beats, wlast on 16th, burst_cnt=1, outst=1, then 0 after bvalid.
//  m0_req and m1_req same cycle, both held -> grant order m0,m1,m0,m1; no overlap; 1 IDLE cycle between bursts.
//  awready held low 10 cycles -> awaddr/awvalid stable, m0_wready=0 throughout, no W beats emitted.
//  wready toggling 1/0, wvalid gaps -> exactly 16 beats, data order preserved, wlast only on beat 15.
//  bvalid withheld, MAX_OUTST=4 -> 4 bursts issue, 5th req not granted until one bvalid, then granted next IDLE.
//  bvalid with bresp=2'b10 -> err=1 stays 1; rst mid-DATA -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/ocm_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write port (AW/W/B) between two burst requesters.
// Grant is held from AW issue to the last W beat; req->awvalid takes 1 cycle, W beats stall on AXI_wready.
module ocm_wr_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic        AXI_clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_awaddr,
    output logic        m0_grant,
    input  logic [31:0] m0_wdata,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    input  logic        m1_req,
    input  logic [31:0] m1_awaddr,
    output logic        m1_grant,
    input  logic [31:0] m1_wdata,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [31:0] AXI_awaddr,
    output logic        AXI_awvalid,
    input  logic        AXI_awready,
    output logic [31:0] AXI_wdata,
    output logic        AXI_wvalid,
    output logic        AXI_wlast,
    input  logic        AXI_wready,
    input  logic        AXI_bvalid,
    input  logic [1:0]  AXI_bresp,
    output logic [3:0]  outst,
    output logic        err,
    output logic [31:0] burst_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);
    localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [3:0]  beat_q, beat_d;
    logic [3:0]  outst_q, outst_d;
    logic        err_q, err_d;
    logic [31:0] burst_cnt_q, burst_cnt_d;

    logic in_data, aw_hs, w_hs, pick;

    assign in_data = (state_q == S_DATA);
    assign aw_hs   = awvalid_q & AXI_awready;
    assign w_hs    = AXI_wvalid & AXI_wready;

    assign m0_grant  = (state_q != S_IDLE) & ~sel_q;
    assign m1_grant  = (state_q != S_IDLE) &  sel_q;
    assign m0_wready = AXI_wready & m0_grant & in_data;
    assign m1_wready = AXI_wready & m1_grant & in_data;

    assign AXI_awaddr  = awaddr_q;
    assign AXI_awvalid = awvalid_q;
    assign AXI_wdata   = sel_q ? m1_wdata : m0_wdata;
    assign AXI_wvalid  = in_data & (sel_q ? m1_wvalid : m0_wvalid);
    assign AXI_wlast   = in_data & (beat_q == BEAT_LAST);

    assign outst     = outst_q;
    assign err       = err_q;
    assign burst_cnt = burst_cnt_q;

    // On a tie the requester that did not own the previous burst wins.
    assign pick = (m0_req && m1_req) ? ~last_q : m1_req;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        beat_d      = beat_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if ((outst_q < OUTST_MAX) && (m0_req || m1_req)) begin
                    sel_d     = pick;
                    awaddr_d  = pick ? m1_awaddr : m0_awaddr;
                    awvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (AXI_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d      = 4'd0;
                        last_d      = sel_q;
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A B response with nothing outstanding is an interconnect protocol error.
    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (aw_hs && !AXI_bvalid) begin
            outst_d = outst_q + 4'd1;
        end else if (!aw_hs && AXI_bvalid && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
        end
        if (AXI_bvalid && ((AXI_bresp != 2'b00) || (outst_q == 4'd0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge AXI_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            awaddr_q    <= 32'd0;
            awvalid_q   <= 1'b0;
            beat_q      <= 4'd0;
            outst_q     <= 4'd0;
            err_q       <= 1'b0;
            burst_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            beat_q      <= beat_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_ocm_wr_arbiter.sv
// Bench for ocm_wr_arbiter: requester/slave models drive random traffic and a burst-level
// reference (grant order, beat order, outstanding count) checks every cycle.
module tb_ocm_wr_arbiter;

    localparam int BL   = 16;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_awaddr = '0, m1_awaddr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_wvalid = 1'b0, m1_wvalid = 1'b0;
    logic        m0_grant, m1_grant, m0_wready, m1_wready;
    logic [31:0] AXI_awaddr, AXI_wdata, burst_cnt;
    logic        AXI_awvalid, AXI_wvalid, AXI_wlast, err;
    logic        AXI_awready = 1'b0, AXI_wready = 1'b0, AXI_bvalid = 1'b0;
    logic [1:0]  AXI_bresp = 2'b00;
    logic [3:0]  outst;

    always #5 clk = ~clk;

    ocm_wr_arbiter #(.BURST_LEN(BL), .MAX_OUTST(MAXO)) dut (
        .AXI_clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_awaddr(m0_awaddr), .m0_grant(m0_grant),
        .m0_wdata(m0_wdata), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m1_req(m1_req), .m1_awaddr(m1_awaddr), .m1_grant(m1_grant),
        .m1_wdata(m1_wdata), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .AXI_awaddr(AXI_awaddr), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
        .AXI_wdata(AXI_wdata), .AXI_wvalid(AXI_wvalid), .AXI_wlast(AXI_wlast),
        .AXI_wready(AXI_wready), .AXI_bvalid(AXI_bvalid), .AXI_bresp(AXI_bresp),
        .outst(outst), .err(err), .burst_cnt(burst_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference state: one burst owner at a time, B responses queued at the slave.
    bit          pend[2];
    logic [31:0] paddr[2];
    int          sent[2] = '{BL, BL};
    int          owner = -1, last_owner = 1, beat = 0;
    bit          aw_done;
    int          m_outst = 0, m_bursts = 0, bq = 0;
    bit          m_err;
    bit          exp_valid;
    int          exp_w = -1;
    int          gq[$];
    int          gcount = 0;

    bit          gap_en, rnd_en, b_hold, wtog;
    int          wr_mode = 0, aw_stall = 0;
    logic [1:0]  bresp_k = 2'b00;

    always @(negedge clk) begin
        logic [1:0] g, mv, mr;
        logic       aw_hs, w_hs, bh;
        int         pre_outst;

        m0_req    = pend[0];
        m1_req    = pend[1];
        m0_awaddr = paddr[0];
        m1_awaddr = paddr[1];
        m0_wvalid = (sent[0] < BL) && (!gap_en || $urandom_range(0, 1) == 1);
        m1_wvalid = (sent[1] < BL) && (!gap_en || $urandom_range(0, 1) == 1);
        m0_wdata  = paddr[0] + 32'(sent[0]);
        m1_wdata  = paddr[1] + 32'(sent[1]);
        if (aw_stall > 0) begin
            AXI_awready = 1'b0;
            if (AXI_awvalid) aw_stall--;
        end else begin
            AXI_awready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        wtog = ~wtog;
        case (wr_mode)
            1:       AXI_wready = wtog;
            2:       AXI_wready = 1'($urandom_range(0, 1));
            default: AXI_wready = 1'b1;
        endcase
        AXI_bvalid = !b_hold && (bq > 0) && (!rnd_en || $urandom_range(0, 1) == 1);
        AXI_bresp  = bresp_k;
        #1;

        if (rst) begin
            owner = -1; last_owner = 1; beat = 0; aw_done = 0;
            m_outst = 0; m_bursts = 0; m_err = 0; bq = 0; exp_valid = 0;
            pend[0] = 0; pend[1] = 0; sent[0] = BL; sent[1] = BL;
        end else begin
            g  = {m1_grant, m0_grant};
            mv = {m1_wvalid, m0_wvalid};
            mr = {m1_wready, m0_wready};
            pre_outst = m_outst;
            chk("grant_excl", 32'(g == 2'b11), 32'd0);
            chk("outst", 32'(outst), 32'(m_outst));
            chk("burst_cnt", burst_cnt, 32'(m_bursts));
            chk("err", 32'(err), 32'(m_err));

            if (owner < 0) begin
                if (exp_valid && exp_w >= 0) begin
                    chk("grant_winner", 32'(g), 32'(1 << exp_w));
                    owner = exp_w; aw_done = 0; beat = 0;
                    pend[owner] = 0; sent[owner] = 0;
                    gq.push_back(owner);
                    gcount++;
                end else begin
                    chk("grant_idle", 32'(g), 32'd0);
                end
            end

            if (owner >= 0) begin
                chk("grant_owner", 32'(g), 32'(1 << owner));
                if (!aw_done) begin
                    chk("awvalid_addr", 32'(AXI_awvalid), 32'd1);
                    chk("awaddr", AXI_awaddr, paddr[owner]);
                    chk("no_w_before_aw", 32'({AXI_wvalid, mr}), 32'd0);
                end else begin
                    chk("awvalid_data", 32'(AXI_awvalid), 32'd0);
                    chk("wvalid_mux", 32'(AXI_wvalid), 32'(mv[owner]));
                    chk("wready_route", 32'(mr), 32'(AXI_wready) << owner);
                end
            end else begin
                chk("idle_quiet", 32'({AXI_awvalid, AXI_wvalid, mr}), 32'd0);
            end
            chk("wlast", 32'(AXI_wlast), 32'(owner >= 0 && aw_done && beat == BL - 1));

            aw_hs = AXI_awvalid & AXI_awready;
            w_hs  = AXI_wvalid & AXI_wready;
            bh    = AXI_bvalid;
            for (int n = 0; n < 2; n++) if (mv[n] && mr[n]) sent[n]++;
            if (owner >= 0 && aw_hs && !aw_done) begin
                aw_done = 1;
                bq++;
            end else if (owner >= 0 && aw_done && w_hs) begin
                chk("wdata", AXI_wdata, paddr[owner] + 32'(beat));
                beat++;
                if (beat == BL) begin
                    m_bursts++;
                    last_owner = owner;
                    owner = -1;
                    beat = 0;
                end
            end
            if (bh) begin
                if (pre_outst == 0 || AXI_bresp != 2'b00) m_err = 1;
                if (bq > 0) bq--;
            end
            if (aw_hs && !bh) m_outst++;
            else if (bh && !aw_hs && m_outst > 0) m_outst--;

            exp_valid = (owner < 0) && (g == 2'b00);
            exp_w = -1;
            if (exp_valid && pre_outst < MAXO) begin
                if (m0_req && m1_req) exp_w = (last_owner == 0) ? 1 : 0;
                else if (m0_req)      exp_w = 0;
                else if (m1_req)      exp_w = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input int n, input logic [31:0] a);
        int i;
        for (i = 0; i < 3000 && (pend[n] || owner == n); i++) tick();
        chk("req_slot_free", 32'(i < 3000), 32'd1);
        paddr[n] = a;
        pend[n]  = 1;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 5000 && (pend[0] || pend[1] || owner >= 0 || bq > 0); i++) tick();
        chk("drain_done", 32'(i < 5000), 32'd1);
        chk("drain_outst", 32'(outst), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grants"}, 32'({m1_grant, m0_grant}), 32'd0);
        chk({tag, "_wready"}, 32'({m1_wready, m0_wready}), 32'd0);
        chk({tag, "_awvalid"}, 32'(AXI_awvalid), 32'd0);
        chk({tag, "_awaddr"}, AXI_awaddr, 32'd0);
        chk({tag, "_wvalid"}, 32'(AXI_wvalid), 32'd0);
        chk({tag, "_wlast"}, 32'(AXI_wlast), 32'd0);
        chk({tag, "_outst"}, 32'(outst), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_burst_cnt"}, burst_cnt, 32'd0);
    endtask

    initial begin
        int i;
        int exp_order[4] = '{0, 1, 0, 1};

        repeat (3) tick();
        check_reset("rst0");
        rst = 0;

        // Single burst, B withheld then released.
        b_hold = 1;
        request(0, 32'hFFFC0000);
        for (i = 0; i < 500 && m_bursts != 1; i++) tick();
        tick();
        chk("t1_burst_cnt", burst_cnt, 32'd1);
        chk("t1_outst_held", 32'(outst), 32'd1);
        b_hold = 0;
        drain();

        // Simultaneous held requests alternate starting with m0.
        rst = 1; tick(); tick(); rst = 0;
        gq.delete();
        request(0, 32'h1000_0000);
        request(1, 32'h2000_0000);
        request(0, 32'h1000_0100);
        request(1, 32'h2000_0100);
        drain();
        chk("t2_grant_count", 32'(gq.size()), 32'd4);
        for (int k = 0; k < 4 && k < gq.size(); k++) chk("t2_grant_order", 32'(gq[k]), 32'(exp_order[k]));

        // AW stalled for 10 cycles while requester already offers beats.
        aw_stall = 10;
        request(0, 32'h3000_0000);
        drain();
        chk("t3_stall_consumed", 32'(aw_stall), 32'd0);

        // Toggling wready with gaps in wvalid.
        wr_mode = 1; gap_en = 1;
        request(1, 32'h4000_0000);
        drain();
        wr_mode = 0; gap_en = 0;

        // Outstanding limit: fifth burst waits for a B response.
        b_hold = 1; gcount = 0;
        request(0, 32'h5000_0000);
        request(1, 32'h5100_0000);
        request(0, 32'h5200_0000);
        request(1, 32'h5300_0000);
        request(0, 32'h5400_0000);
        for (i = 0; i < 1000 && !(m_outst == MAXO && owner < 0); i++) tick();
        repeat (20) tick();
        chk("t5_grants_capped", 32'(gcount), 32'd4);
        chk("t5_outst_max", 32'(outst), 32'(MAXO));
        chk("t5_req_waiting", 32'({m0_grant, m0_req}), 32'b01);
        b_hold = 0;
        drain();
        chk("t5_grants_total", 32'(gcount), 32'd5);

        // Randomized traffic from both requesters.
        rnd_en = 1; gap_en = 1; wr_mode = 2;
        for (int k = 0; k < 24; k++) request(int'($urandom_range(0, 1)), $urandom);
        drain();
        rnd_en = 0; gap_en = 0; wr_mode = 0;

        // SLVERR response makes err sticky.
        bresp_k = 2'b10;
        request(0, 32'h6000_0000);
        for (i = 0; i < 500 && (owner >= 0 || pend[0] || bq > 0); i++) tick();
        bresp_k = 2'b00;
        tick();
        chk("t7_err_set", 32'(err), 32'd1);
        request(1, 32'h6100_0000);
        drain();
        chk("t7_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of the data phase.
        request(0, 32'h7000_0000);
        for (i = 0; i < 500 && !(owner == 0 && aw_done && beat >= 3); i++) tick();
        chk("t8_mid_data_reached", 32'(i < 500), 32'd1);
        rst = 1;
        tick();
        check_reset("rst_mid");
        rst = 0;
        request(1, 32'h7100_0000);
        drain();
        chk("t8_recover_cnt", burst_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
